// File: rtl/pll_reset_sequencer.sv
// Holds a set of ordered reset domains until the PLL lock has been stable, then releases them one by one.
// Any lock drop or software request re-asserts every domain; lock drops after stability are counted.
module pll_reset_sequencer #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned LOSS_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              locked,
    input  logic              sw_reset,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic [LOSS_W-1:0] lock_loss_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int unsigned CNT_MAX = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STAGES - 1);

    logic              r_sync1;
    logic              r_locked_s;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [STAGES-1:0] r_rst_out;
    logic              r_ready;
    logic [LOSS_W-1:0] r_loss;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [STAGES-1:0] w_rst_nxt;
    logic              w_ready_nxt;
    logic [LOSS_W-1:0] w_loss_nxt;
    logic              w_abort;
    logic              w_count_loss;

    // State and datapath registers; locked is resynchronised through two flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_out  <= '1;
            r_ready    <= 1'b0;
            r_loss     <= '0;
        end else begin
            r_sync1    <= locked;
            r_locked_s <= r_sync1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_rst_out  <= w_rst_nxt;
            r_ready    <= w_ready_nxt;
            r_loss     <= w_loss_nxt;
        end
    end

    // Next-state logic; a lock drop outranks sw_reset so it is always counted.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_rst_nxt    = r_rst_out;
        w_ready_nxt  = r_ready;
        w_loss_nxt   = r_loss;
        w_abort      = 1'b0;
        w_count_loss = 1'b0;

        case (r_state)
            WAIT_LOCK: begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_rst_nxt   = '1;
                w_ready_nxt = 1'b0;
                if (r_locked_s && !sw_reset) begin
                    w_state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (!r_locked_s || sw_reset) begin
                    w_abort = 1'b1;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!r_locked_s) begin
                    w_abort      = 1'b1;
                    w_count_loss = 1'b1;
                end else if (sw_reset) begin
                    w_abort = 1'b1;
                end else if (r_cnt == GAP_LAST) begin
                    // Shifting in zeros from bit 0 keeps the release order monotonic.
                    w_rst_nxt = STAGES'(r_rst_out << 1);
                    w_cnt_nxt = '0;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!r_locked_s) begin
                    w_abort      = 1'b1;
                    w_count_loss = 1'b1;
                end else if (sw_reset) begin
                    w_abort = 1'b1;
                end
            end
            default: begin
                w_abort = 1'b1;
            end
        endcase

        if (w_abort) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
        end
        if (w_count_loss && (r_loss != {LOSS_W{1'b1}})) begin
            w_loss_nxt = r_loss + LOSS_W'(1);
        end
    end

    assign rst_out         = r_rst_out;
    assign ready           = r_ready;
    assign lock_loss_count = r_loss;
    assign state           = r_state;

endmodule
